// File: rtl/dcache_tag_nway.sv
// N-way set-associative data-cache tag store with tree pseudo-LRU replacement.
// Self-clears after reset with a set sweep. Lookups are registered and compared one cycle later.
module dcache_tag_nway #(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned SETS     = 128,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned ADDR_W   = 32,
    localparam int unsigned IDX_W   = $clog2(SETS),
    localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFFSET_W,
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [WAY_W-1:0]  hit_way,
    output logic [WAY_W-1:0]  victim_way,
    output logic              victim_valid,
    output logic              victim_dirty,
    output logic [TAG_W-1:0]  victim_tag,
    input  logic              wen,
    input  logic [IDX_W-1:0]  w_index,
    input  logic [WAY_W-1:0]  w_way,
    input  logic [TAG_W-1:0]  w_tag,
    input  logic              w_valid,
    input  logic              w_dirty,
    input  logic              set_dirty,
    output logic              work
);

    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    // Tree node bit = direction of the next victim (0 = lower half); children of the root at 1 and 2.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                     input logic [WAY_W-1:0]  w);
        logic [PLRU_W-1:0] r;
        r = p;
        if (WAYS == 2) begin
            r[0] = ~w[0];
        end else if (WAYS == 4) begin
            r[0] = ~w[WAY_W-1];
            if (w[WAY_W-1]) r[PLRU_W-1] = ~w[0];
            else            r[PLRU_W/2] = ~w[0];
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
        logic [WAY_W-1:0] v;
        v = '0;
        if (WAYS == 2) begin
            v[0] = p[0];
        end else if (WAYS == 4) begin
            v[WAY_W-1] = p[0];
            v[0]       = p[0] ? p[PLRU_W-1] : p[PLRU_W/2];
        end
        return v;
    endfunction

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAYS-1:0]   dirty_d [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [PLRU_W-1:0] plru_q  [SETS];
    logic [PLRU_W-1:0] plru_d  [SETS];

    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              work_q, work_d;
    logic              lk_q, lk_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;
    logic [WAYS-1:0]   rd_valid_q, rd_valid_d;
    logic [WAYS-1:0]   rd_dirty_q, rd_dirty_d;
    logic [TAG_W-1:0]  rd_tags_q [WAYS];
    logic [TAG_W-1:0]  rd_tags_d [WAYS];
    logic [PLRU_W-1:0] rd_plru_q, rd_plru_d;

    logic [IDX_W-1:0]  a_idx;
    logic [TAG_W-1:0]  a_tag;
    logic              unused_ok;

    assign a_idx     = addr[OFFSET_W +: IDX_W];
    assign a_tag     = addr[ADDR_W-1 -: TAG_W];
    assign unused_ok = ^addr[OFFSET_W-1:0];
    assign work      = work_q;

    // Compare against the registered set snapshot; lowest way wins on both hit and invalid search.
    always_comb begin
        logic found;
        hit        = 1'b0;
        hit_way    = '0;
        found      = 1'b0;
        victim_way = plru_victim(rd_plru_q);
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (rd_valid_q[i] && (rd_tags_q[i] == rd_tag_q) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!rd_valid_q[i] && !found) begin
                found      = 1'b1;
                victim_way = WAY_W'(i);
            end
        end
        victim_valid = rd_valid_q[victim_way];
        victim_dirty = rd_dirty_q[victim_way];
        victim_tag   = rd_tags_q[victim_way];
    end

    // Sweep, then per cycle: hit touch / store-hit dirty, write (applied last), write-first lookup capture.
    always_comb begin
        cnt_d      = cnt_q;
        work_d     = work_q;
        lk_d       = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_tag_d   = rd_tag_q;
        rd_valid_d = rd_valid_q;
        rd_dirty_d = rd_dirty_q;
        rd_tags_d  = rd_tags_q;
        rd_plru_d  = rd_plru_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        plru_d     = plru_q;
        if (!work_q) begin
            valid_d[cnt_q] = '0;
            dirty_d[cnt_q] = '0;
            plru_d[cnt_q]  = '0;
            for (int unsigned w = 0; w < WAYS; w++) tag_d[cnt_q][w] = '0;
            if (cnt_q == IDX_W'(SETS - 1)) work_d = 1'b1;
            else                           cnt_d  = cnt_q + IDX_W'(1);
        end else begin
            if (lk_q && hit) begin
                plru_d[rd_idx_q] = plru_touch(plru_q[rd_idx_q], hit_way);
                if (set_dirty) dirty_d[rd_idx_q][hit_way] = 1'b1;
            end
            if (wen) begin
                valid_d[w_index][w_way] = w_valid;
                dirty_d[w_index][w_way] = w_dirty;
                tag_d[w_index][w_way]   = w_tag;
                if (w_valid) plru_d[w_index] = plru_touch(plru_d[w_index], w_way);
            end
            if (req) begin
                lk_d       = 1'b1;
                rd_idx_d   = a_idx;
                rd_tag_d   = a_tag;
                rd_valid_d = valid_d[a_idx];
                rd_dirty_d = dirty_d[a_idx];
                rd_tags_d  = tag_d[a_idx];
                rd_plru_d  = plru_d[a_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            work_q     <= 1'b0;
            lk_q       <= 1'b0;
            rd_idx_q   <= '0;
            rd_tag_q   <= '0;
            rd_valid_q <= '0;
            rd_dirty_q <= '0;
            rd_plru_q  <= '0;
            for (int unsigned w = 0; w < WAYS; w++) rd_tags_q[w] <= '0;
        end else begin
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            lk_q       <= lk_d;
            rd_idx_q   <= rd_idx_d;
            rd_tag_q   <= rd_tag_d;
            rd_valid_q <= rd_valid_d;
            rd_dirty_q <= rd_dirty_d;
            rd_plru_q  <= rd_plru_d;
            rd_tags_q  <= rd_tags_d;
        end
    end

    // Array contents are cleared by the sweep, not by reset.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        dirty_q <= dirty_d;
        tag_q   <= tag_d;
        plru_q  <= plru_d;
    end

endmodule

// File: tb/tb_dcache_tag_nway.sv
// Bench for dcache_tag_nway (2 ways, 128 sets): directed scenarios plus random traffic
// checked against a per-set LRU-way model of the tag store.
module tb_dcache_tag_nway;

    localparam int unsigned WAYS     = 2;
    localparam int unsigned SETS     = 128;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned IDX_W    = 7;
    localparam int unsigned TAG_W    = 20;
    localparam int unsigned WAY_W    = 1;

    logic              clk = 1'b0;
    logic              rst, req, wen, w_valid, w_dirty, set_dirty;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  w_index;
    logic [WAY_W-1:0]  w_way;
    logic [TAG_W-1:0]  w_tag;
    logic              hit, victim_valid, victim_dirty, work;
    logic [WAY_W-1:0]  hit_way, victim_way;
    logic [TAG_W-1:0]  victim_tag;

    int total = 0;
    int bad   = 0;

    dcache_tag_nway #(.WAYS(WAYS), .SETS(SETS), .OFFSET_W(OFFSET_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr),
        .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .wen(wen), .w_index(w_index), .w_way(w_way), .w_tag(w_tag),
        .w_valid(w_valid), .w_dirty(w_dirty), .set_dirty(set_dirty), .work(work)
    );

    always #5 clk = ~clk;

    // Model: contents per set/way, the least-recently-touched way per set, and the lookup snapshot.
    logic             m_valid [SETS][WAYS];
    logic             m_dirty [SETS][WAYS];
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    int               m_lru   [SETS];
    logic             s_valid [WAYS];
    logic             s_dirty [WAYS];
    logic [TAG_W-1:0] s_tags  [WAYS];
    logic [TAG_W-1:0] s_tag;
    int               s_idx, s_lru, m_cnt;
    bit               m_lk, m_work;

    bit               e_hit, e_vvalid, e_vdirty;
    int               e_hway, e_vway;
    logic [TAG_W-1:0] e_vtag;

    logic [TAG_W-1:0] tag_pool [4];
    int               idx_pool [4];

    task automatic model_out();
        e_hit  = 1'b0;
        e_hway = 0;
        e_vway = -1;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!e_hit && s_valid[w] && s_tags[w] == s_tag) begin
                e_hit  = 1'b1;
                e_hway = w;
            end
            if (e_vway < 0 && !s_valid[w]) e_vway = w;
        end
        if (e_vway < 0) e_vway = s_lru;
        e_vvalid = s_valid[e_vway];
        e_vdirty = s_dirty[e_vway];
        e_vtag   = s_tags[e_vway];
    endtask

    task automatic model_step();
        int idx;
        if (rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                m_lru[s] = 0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    m_valid[s][w] = 1'b0;
                    m_dirty[s][w] = 1'b0;
                    m_tag[s][w]   = '0;
                end
            end
            for (int w = 0; w < int'(WAYS); w++) begin
                s_valid[w] = 1'b0;
                s_dirty[w] = 1'b0;
                s_tags[w]  = '0;
            end
            s_tag = '0; s_idx = 0; s_lru = 0; m_lk = 1'b0; m_work = 1'b0; m_cnt = 0;
        end else if (!m_work) begin
            m_cnt++;
            if (m_cnt == int'(SETS)) m_work = 1'b1;
        end else begin
            model_out();
            if (m_lk && e_hit) begin
                m_lru[s_idx] = 1 - e_hway;
                if (set_dirty) m_dirty[s_idx][e_hway] = 1'b1;
            end
            if (wen) begin
                m_valid[w_index][w_way] = w_valid;
                m_dirty[w_index][w_way] = w_dirty;
                m_tag[w_index][w_way]   = w_tag;
                if (w_valid) m_lru[w_index] = 1 - int'(w_way);
            end
            if (req) begin
                idx = int'(addr[OFFSET_W +: IDX_W]);
                for (int w = 0; w < int'(WAYS); w++) begin
                    s_valid[w] = m_valid[idx][w];
                    s_dirty[w] = m_dirty[idx][w];
                    s_tags[w]  = m_tag[idx][w];
                end
                s_tag = addr[ADDR_W-1 -: TAG_W];
                s_lru = m_lru[idx];
                s_idx = idx;
                m_lk  = 1'b1;
            end else begin
                m_lk = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; wen = 1'b0; set_dirty = 1'b0; addr = '0;
        w_index = '0; w_way = '0; w_tag = '0; w_valid = 1'b0; w_dirty = 1'b0;
    endtask

    task automatic write(input int idx, input int way, input logic [TAG_W-1:0] t,
                         input logic v, input logic d);
        wen = 1'b1; w_index = IDX_W'(idx); w_way = WAY_W'(way); w_tag = t;
        w_valid = v; w_dirty = d;
        cycle();
        idle();
    endtask

    task automatic lookup(input logic [ADDR_W-1:0] a);
        req = 1'b1; addr = a;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        int rise_at;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        total++; if (hit !== 1'b0 || victim_way !== 1'b0 || victim_valid !== 1'b0 ||
                     victim_dirty !== 1'b0 || victim_tag !== '0 || work !== 1'b0) begin
            bad++; $display("FAIL reset.outputs got hit=%0b vw=%0b vv=%0b vd=%0b vt=%h work=%0b want all 0",
                            hit, victim_way, victim_valid, victim_dirty, victim_tag, work);
        end
        rise_at = -1;
        for (int c = 1; c <= 200; c++) begin
            // Writes to set 0 after it has been swept must be ignored.
            if (c >= 2) begin
                wen = 1'b1; w_index = '0; w_way = '0; w_tag = '0; w_valid = 1'b1; w_dirty = 1'b1;
                req = 1'b1; addr = 32'h0;
            end
            cycle();
            if (work === 1'b1) begin
                rise_at = c;
                break;
            end
            total++; if (hit !== 1'b0) begin
                bad++; $display("FAIL reset.sweep_hit c=%0d got=%0b want=0", c, hit);
            end
        end
        idle();
        total++; if (rise_at != 128) begin
            bad++; $display("FAIL reset.work_rise got=%0d want=128", rise_at);
        end
        lookup(32'h0000_0000);
        total++; if (hit !== 1'b0 || victim_way !== 1'b0 || victim_valid !== 1'b0) begin
            bad++; $display("FAIL reset.first_lookup got hit=%0b vw=%0b vv=%0b want 0 0 0",
                            hit, victim_way, victim_valid);
        end
    endtask

    task automatic test_fill_hit();
        write(5, 1, 20'h12345, 1'b1, 1'b0);
        lookup(32'h1234_50A0);
        total++; if (hit !== 1'b1 || hit_way !== 1'b1) begin
            bad++; $display("FAIL fill.hit got hit=%0b way=%0b want 1 1", hit, hit_way);
        end
        lookup(32'h5432_10A0);
        total++; if (hit !== 1'b0 || victim_way !== 1'b0 || victim_valid !== 1'b0) begin
            bad++; $display("FAIL fill.miss got hit=%0b vw=%0b vv=%0b want 0 0 0", hit, victim_way, victim_valid);
        end
    endtask

    task automatic test_evict();
        write(5, 0, 20'hAAAAA, 1'b1, 1'b1);
        write(5, 1, 20'hBBBBB, 1'b1, 1'b0);
        lookup(32'hBBBB_B0A0);
        total++; if (hit !== 1'b1 || hit_way !== 1'b1) begin
            bad++; $display("FAIL evict.hit got hit=%0b way=%0b want 1 1", hit, hit_way);
        end
        lookup(32'h5432_10A0);
        total++; if (hit !== 1'b0 || victim_way !== 1'b0 || victim_valid !== 1'b1 ||
                     victim_dirty !== 1'b1 || victim_tag !== 20'hAAAAA) begin
            bad++; $display("FAIL evict.victim got hit=%0b vw=%0b vv=%0b vd=%0b vt=%h want 0 0 1 1 aaaaa",
                            hit, victim_way, victim_valid, victim_dirty, victim_tag);
        end
    endtask

    task automatic test_store_hit();
        lookup(32'hBBBB_B0A0);
        total++; if (hit !== 1'b1 || hit_way !== 1'b1) begin
            bad++; $display("FAIL store.hit got hit=%0b way=%0b want 1 1", hit, hit_way);
        end
        set_dirty = 1'b1;
        cycle();
        idle();
        lookup(32'hAAAA_A0A0);
        total++; if (hit !== 1'b1 || hit_way !== 1'b0) begin
            bad++; $display("FAIL store.touch0 got hit=%0b way=%0b want 1 0", hit, hit_way);
        end
        lookup(32'h5432_10A0);
        total++; if (hit !== 1'b0 || victim_way !== 1'b1 || victim_dirty !== 1'b1 ||
                     victim_tag !== 20'hBBBBB) begin
            bad++; $display("FAIL store.victim got hit=%0b vw=%0b vd=%0b vt=%h want 0 1 1 bbbbb",
                            hit, victim_way, victim_dirty, victim_tag);
        end
    endtask

    task automatic test_bypass();
        req = 1'b1; addr = 32'hBBBB_B0A0;
        wen = 1'b1; w_index = 7'h05; w_way = 1'b1; w_tag = 20'hBBBBB; w_valid = 1'b0; w_dirty = 1'b0;
        cycle();
        idle();
        total++; if (hit !== 1'b0 || victim_way !== 1'b1 || victim_valid !== 1'b0) begin
            bad++; $display("FAIL bypass.inval got hit=%0b vw=%0b vv=%0b want 0 1 0", hit, victim_way, victim_valid);
        end
    endtask

    task automatic test_snapshot();
        lookup(32'hAAAA_A0A0);
        total++; if (hit !== 1'b1 || hit_way !== 1'b0) begin
            bad++; $display("FAIL snap.hit got hit=%0b way=%0b want 1 0", hit, hit_way);
        end
        write(5, 0, 20'hAAAAA, 1'b0, 1'b0);
        total++; if (hit !== 1'b1 || hit_way !== 1'b0 || victim_way !== 1'b1) begin
            bad++; $display("FAIL snap.hold got hit=%0b way=%0b vw=%0b want 1 0 1", hit, hit_way, victim_way);
        end
    endtask

    task automatic test_random();
        int ri, wi;
        logic [TAG_W-1:0] rt;
        for (int n = 0; n < 3000; n++) begin
            model_out();
            ri = idx_pool[$urandom_range(0, 3)];
            rt = tag_pool[$urandom_range(0, 3)];
            req  = ($urandom_range(0, 2) != 0);
            addr = {rt, IDX_W'(ri), OFFSET_W'($urandom_range(0, 31))};
            wi = idx_pool[$urandom_range(0, 3)];
            wen     = ($urandom_range(0, 2) == 0);
            w_index = IDX_W'(wi);
            w_tag   = tag_pool[$urandom_range(0, 3)];
            w_valid = ($urandom_range(0, 3) != 0);
            w_dirty = 1'($urandom_range(0, 1));
            w_way   = WAY_W'($urandom_range(0, 1));
            // A legal controller never installs a tag already resident in another way.
            if (wen && w_valid)
                for (int w = 0; w < int'(WAYS); w++)
                    if (m_valid[wi][w] && m_tag[wi][w] == w_tag) w_way = WAY_W'(w);
            set_dirty = m_lk && e_hit && ($urandom_range(0, 1) == 1);
            cycle();
            model_out();
            total++; if (hit !== e_hit) begin
                bad++; $display("FAIL rnd.hit n=%0d got=%0b want=%0b", n, hit, e_hit);
            end
            if (e_hit) begin
                total++; if (hit_way !== WAY_W'(e_hway)) begin
                    bad++; $display("FAIL rnd.hit_way n=%0d got=%0d want=%0d", n, hit_way, e_hway);
                end
            end
            total++; if (victim_way !== WAY_W'(e_vway) || victim_valid !== e_vvalid ||
                         victim_dirty !== e_vdirty || victim_tag !== e_vtag) begin
                bad++; $display("FAIL rnd.victim n=%0d got w=%0d v=%0b d=%0b t=%h want w=%0d v=%0b d=%0b t=%h",
                                n, victim_way, victim_valid, victim_dirty, victim_tag,
                                e_vway, e_vvalid, e_vdirty, e_vtag);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int rise_at;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 60; c++) cycle();
        total++; if (work !== 1'b0) begin
            bad++; $display("FAIL rmid.early_work got=%0b want=0", work);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rise_at = -1;
        for (int c = 1; c <= 200; c++) begin
            cycle();
            if (work === 1'b1) begin
                rise_at = c;
                break;
            end
        end
        total++; if (rise_at != 128) begin
            bad++; $display("FAIL rmid.work_rise got=%0d want=128", rise_at);
        end
        lookup(32'hBBBB_B0A0);
        lookup(32'h1234_50A0);
        total++; if (hit !== 1'b0 || victim_valid !== 1'b0 || victim_way !== 1'b0) begin
            bad++; $display("FAIL rmid.cleared got hit=%0b vv=%0b vw=%0b want 0 0 0", hit, victim_valid, victim_way);
        end
    endtask

    initial begin
        tag_pool[0] = 20'h12345; tag_pool[1] = 20'hAAAAA;
        tag_pool[2] = 20'hBBBBB; tag_pool[3] = 20'h00001;
        idx_pool[0] = 5; idx_pool[1] = 0; idx_pool[2] = 127; idx_pool[3] = 64;
        rst = 1'b1;
        idle();
        test_reset();
        test_fill_hit();
        test_evict();
        test_store_hit();
        test_bypass();
        test_snapshot();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
